// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg: shared types and defaults for the counter arbiter.
//   state_e     - FSM state encoding (idle, counting run, completion pulse)
//   NreqDefault - default number of requesters
//   CwDefault   - default shared counter width
//   idx_w()     - width of a requester index, never below one bit
package counter_arbiter_pkg;

    localparam int unsigned NreqDefault = 4;
    localparam int unsigned CwDefault   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: request/grant/counter bundle between requesters and the arbiter.
//   req     - level request per requester, held until that requester's done
//   len     - per-requester terminal count, slice i belongs to requester i
//   grant   - one-hot (or zero) ownership
//   count   - shared counter value
//   busy    - arbiter not idle
//   done    - one-cycle completion pulse
//   done_id - requester whose run completed, valid while done is high
// Modports: master (requester side), slave (arbiter side).
interface counter_arbiter_if
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NreqDefault,
    parameter int unsigned CW   = CwDefault
) ();

    localparam int unsigned IdxW = idx_w(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [CW-1:0]      count;
    logic               busy;
    logic               done;
    logic [IdxW-1:0]    done_id;

    modport master (
        output req, len,
        input  grant, count, busy, done, done_id
    );

    modport slave (
        input  req, len,
        output grant, count, busy, done, done_id
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i   - request vector
//   ptr_i   - index of the last granted requester; search starts just after it
//   gnt_o   - one-hot winner (zero when nothing requested)
//   valid_o - high when some request is present
module rr_pick
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NreqDefault
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [idx_w(NREQ)-1:0]  ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    valid_o
);

    localparam int unsigned IdxW = idx_w(NREQ);

    logic [IdxW-1:0] sel;

    // Walk ptr+1, ptr+2, ... wrapping; the first set bit wins, so ptr itself is lowest priority.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        sel     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            sel = IdxW'((32'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared counter to a requester.
// The winner's counter runs 0..len (len latched at grant), then a one-cycle done
// pulse names the winner and the arbiter returns to idle.
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   bus_io - counter_arbiter_if.slave (req, len in; grant, count, busy, done, done_id out)
// Optional feature: define COUNTER_ARBITER_ABORT_EN so that dropping the winner's
// request mid-run ends the run early (count frozen, done still pulsed).
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NreqDefault,
    parameter int unsigned CW   = CwDefault
) (
    input  logic               clk,
    input  logic               reset,
    counter_arbiter_if.slave   bus_io
);

    localparam int unsigned IdxW = idx_w(NREQ);

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   len_q;
    logic            done_q;
    logic [IdxW-1:0] done_id_q;
    logic [IdxW-1:0] winner_q;
    logic [IdxW-1:0] ptr_q;

    logic [NREQ-1:0] win_oh;
    logic            win_valid;
    logic [IdxW-1:0] win_idx;
    logic [CW-1:0]   win_len;
    logic            abort;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i   (bus_io.req),
        .ptr_i   (ptr_q),
        .gnt_o   (win_oh),
        .valid_o (win_valid)
    );

    always_comb begin
        win_idx = '0;
        win_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IdxW'(i);
                win_len = bus_io.len[i*CW +: CW];
            end
        end
    end

`ifdef COUNTER_ARBITER_ABORT_EN
    assign abort = ~bus_io.req[winner_q];
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            count_q   <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            winner_q  <= '0;
            // Last-granted = NREQ-1 makes requester 0 first in line.
            ptr_q     <= IdxW'(NREQ - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (win_valid) begin
                        state_q  <= StRun;
                        grant_q  <= win_oh;
                        count_q  <= '0;
                        len_q    <= win_len;
                        winner_q <= win_idx;
                    end
                end
                StRun: begin
                    // Terminal compare stops before increment, so count never wraps.
                    if (abort || (count_q == len_q)) begin
                        state_q   <= StDone;
                        grant_q   <= '0;
                        done_q    <= 1'b1;
                        done_id_q <= winner_q;
                        ptr_q     <= winner_q;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.grant   = grant_q;
    assign bus_io.count   = count_q;
    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = done_q;
    assign bus_io.done_id = done_id_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: self-checking bench for counter_arbiter (NREQ=4, CW=4).
// Directed table of single runs, hand sequences for round-robin, reset mid-run and
// early request drop, then random episodes checked against a schedule model.
module tb_counter_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   mdl_ptr;

    counter_arbiter_if #(.NREQ(4), .CW(4)) bus ();

    counter_arbiter #(
        .NREQ (4),
        .CW   (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  exp_grant;
        int          exp_cycles;
        logic [3:0]  exp_last;
        logic [1:0]  exp_id;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic [1:0] id;
        bit         drop;
    } exp_t;

    vec_t vecs[5];
    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bus.req = '0;
        tick();
        tick();
        reset   = 1'b1;
        mdl_ptr = 3;
    endtask

    // Schedule model: each granted run is len+1 counting cycles, one done cycle,
    // one idle cycle; the winner is the next requester after the previous winner.
    task automatic build(input logic [3:0] mask, input logic [15:0] lv, input int runs);
        int w;
        int l;
        for (int r = 0; r < runs; r++) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && mask[(mdl_ptr + k) % 4]) w = (mdl_ptr + k) % 4;
            end
            mdl_ptr = w;
            l = int'(lv[w*4 +: 4]);
            for (int c = 0; c <= l; c++) begin
                q.push_back('{4'(1 << w), 4'(c), 1'b1, 1'b0, 2'd0, 1'b0});
            end
            q.push_back('{4'd0, 4'(l), 1'b1, 1'b1, 2'(w), (r == runs - 1)});
            q.push_back('{4'd0, 4'(l), 1'b0, 1'b0, 2'd0, 1'b0});
        end
    endtask

    initial begin
        int n;
        int guard;
        logic [3:0] mask;
        logic [15:0] lv;
        exp_t e;

        checks  = 0;
        errors  = 0;
        mdl_ptr = 3;
        reset   = 1'b0;
        bus.req = '0;
        bus.len = '0;

        vecs[0] = '{4'b0001, 16'h0003, 4'b0001, 4,  4'd3,  2'd0};
        vecs[1] = '{4'b0100, 16'h0000, 4'b0100, 1,  4'd0,  2'd2};
        vecs[2] = '{4'b1000, 16'hF000, 4'b1000, 16, 4'd15, 2'd3};
        vecs[3] = '{4'b0110, 16'h0020, 4'b0010, 3,  4'd2,  2'd1};
        vecs[4] = '{4'b1010, 16'h3050, 4'b0010, 6,  4'd5,  2'd1};

        // Reset state, checked before any clock edge.
        #2;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);

        // Directed single runs from reset.
        foreach (vecs[v]) begin
            do_reset();
            bus.req = vecs[v].req;
            bus.len = vecs[v].len;
            tick();
            chk("vec_grant", 32'(bus.grant), 32'(vecs[v].exp_grant));
            chk("vec_count0", 32'(bus.count), 32'd0);
            chk("vec_busy", 32'(bus.busy), 32'd1);
            n = 1;
            guard = 0;
            while (bus.done !== 1'b1 && guard < 40) begin
                tick();
                guard++;
                if (bus.done !== 1'b1) begin
                    chk("vec_count", 32'(bus.count), 32'(n));
                    n++;
                end
            end
            if (guard >= 40) begin
                checks++;
                errors++;
                $display("FAIL vec_timeout: no done after %0d cycles, expected within 40", guard);
            end
            chk("vec_run_cycles", 32'(n), 32'(vecs[v].exp_cycles));
            chk("vec_last_count", 32'(bus.count), 32'(vecs[v].exp_last));
            chk("vec_done_id", 32'(bus.done_id), 32'(vecs[v].exp_id));
            chk("vec_done_grant", 32'(bus.grant), 32'd0);
            bus.req = '0;
            tick();
            chk("vec_idle_done", 32'(bus.done), 32'd0);
            chk("vec_idle_busy", 32'(bus.busy), 32'd0);
            chk("vec_idle_count", 32'(bus.count), 32'(vecs[v].exp_last));
        end

        // All four requesting, len=1: grants 0,1,2,3,0 with 2 run + 1 done cycles each.
        do_reset();
        bus.req = 4'b1111;
        bus.len = 16'h1111;
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("rr_grant_c0", 32'(bus.grant), 32'(1 << (r % 4)));
            chk("rr_count_c0", 32'(bus.count), 32'd0);
            tick();
            chk("rr_grant_c1", 32'(bus.grant), 32'(1 << (r % 4)));
            chk("rr_count_c1", 32'(bus.count), 32'd1);
            tick();
            chk("rr_done", 32'(bus.done), 32'd1);
            chk("rr_done_id", 32'(bus.done_id), 32'(r % 4));
            chk("rr_done_grant", 32'(bus.grant), 32'd0);
            if (r == 4) bus.req = '0;
            tick();
            chk("rr_idle_busy", 32'(bus.busy), 32'd0);
        end

        // Reset asserted mid-run at count=5: outputs clear at once, no done pulse.
        do_reset();
        bus.req = 4'b0001;
        bus.len = 16'h000A;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_count5", 32'(bus.count), 32'd5);
        #2;
        reset   = 1'b0;
        bus.req = '0;
        #1;
        chk("mid_grant", 32'(bus.grant), 32'd0);
        chk("mid_count", 32'(bus.count), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_done", 32'(bus.done), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("mid_after_done", 32'(bus.done), 32'd0);

        // Request dropped at count=4 with len=10.
        do_reset();
        bus.req = 4'b0001;
        bus.len = 16'h000A;
        for (int i = 0; i < 5; i++) tick();
        chk("drop_count4", 32'(bus.count), 32'd4);
        bus.req = '0;
        tick();
`ifdef COUNTER_ARBITER_ABORT_EN
        chk("abort_done", 32'(bus.done), 32'd1);
        chk("abort_count", 32'(bus.count), 32'd4);
        chk("abort_grant", 32'(bus.grant), 32'd0);
        chk("abort_done_id", 32'(bus.done_id), 32'd0);
        tick();
        chk("abort_idle", 32'(bus.busy), 32'd0);
`else
        chk("noabort_run", 32'(bus.done), 32'd0);
        guard = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("FAIL noabort_timeout: no done after %0d cycles, expected within 20", guard);
        end
        chk("noabort_count", 32'(bus.count), 32'd10);
`endif

        // Random episodes against the schedule model.
        do_reset();
        for (int ep = 0; ep < 30; ep++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) lv[i*4 +: 4] = 4'($urandom_range(0, 6));
            build(mask, lv, int'($urandom_range(1, 5)));
            bus.req = mask;
            bus.len = lv;
            while (q.size() > 0) begin
                e = q.pop_front();
                tick();
                chk("rnd_grant", 32'(bus.grant), 32'(e.grant));
                chk("rnd_count", 32'(bus.count), 32'(e.count));
                chk("rnd_busy", 32'(bus.busy), 32'(e.busy));
                chk("rnd_done", 32'(bus.done), 32'(e.done));
                if (e.done) chk("rnd_done_id", 32'(bus.done_id), 32'(e.id));
                if (e.drop) bus.req = '0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters.
REQ-002 Parameter CW, default 4, SHALL set the width of the shared counter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (asserted when 0).
REQ-005 req  input  NREQ  SHALL carry level requests, one bit per requester, held high until that requester's done.
REQ-006 len  input  NREQ*CW  SHALL carry the per-requester terminal count; slice i belongs to requester i.
REQ-007 grant  output  NREQ  SHALL be a one-hot (or zero) ownership indication.
REQ-008 count  output  CW  SHALL be the shared counter value.
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 done_id  output  $clog2(NREQ)  SHALL identify the requester whose run completed; valid only while done=1.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE with any req bit set SHALL select a winner round-robin, starting at the index after the last granted one, and SHALL move to RUN on the next edge.
REQ-014 On entry to RUN: grant[winner]=1, count=0, winner's len latched. Later len changes SHALL be ignored.
REQ-015 Latency: req rising in IDLE SHALL see grant one cycle later.
REQ-016 RUN: count SHALL increment by 1 each cycle; when count equals the latched len, the next state SHALL be DONE and count SHALL hold.
REQ-017 len=0 SHALL give exactly one RUN cycle with count=0.
REQ-018 count SHALL never wrap; maximum len is 2^CW-1.
REQ-019 DONE: done=1, done_id=winner, grant=0, count held. The next state SHALL be IDLE unconditionally.
REQ-020 Round-robin pointer update: it SHALL point at the winner once DONE is reached.
REQ-021 A requester still holding req after its done SHALL re-enter arbitration at the lowest priority.
REQ-022 Requests arriving during RUN or DONE SHALL wait; there is no preemption.
REQ-023 In IDLE: grant=0, done=0, count SHALL hold its last value.

Reset
REQ-024 reset low SHALL immediately force IDLE, grant=0, count=0, done=0, done_id=0, busy=0, and round-robin pointer so that requester 0 has top priority.
REQ-025 Reset asserted mid-RUN SHALL abandon the run with no done pulse.

Configuration
REQ-026 With COUNTER_ARBITER_ABORT_EN defined: dropping req[winner] during RUN SHALL go to DONE on the next edge, with done pulsed and count frozen at its current value.
REQ-027 With COUNTER_ARBITER_ABORT_EN undefined: req drops during RUN SHALL be ignored and the run SHALL complete to len.

Structure
REQ-028 Package counter_arbiter_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default NREQ/CW constants.
REQ-029 Round-robin selection SHALL live in sub-module rr_pick. Inputs: req vector and pointer. Outputs: one-hot winner and a valid flag. It is purely combinational.

Verification
REQ-030 Bench SHALL cover: req=0001, len0=3 -> grant=0001 one cycle later; count 0,1,2,3; then done=1, done_id=0; grant=0.
REQ-031 Bench SHALL cover: req=1111 held, all len=1 -> grant order 0,1,2,3,0; every run is 2 RUN cycles plus 1 DONE cycle.
REQ-032 Bench SHALL cover: len=0 on requester 2 alone -> one RUN cycle with count=0, then done_id=2.
REQ-033 Bench SHALL cover: len=15, CW=4 -> count reaches 15, no wrap to 0, done follows.
REQ-034 Bench SHALL cover: reset driven low while count=5 in RUN -> same-time grant=0, count=0, busy=0, no done pulse.
REQ-035 Bench SHALL cover: with ABORT_EN, len=10 and req dropped at count=4 -> DONE next cycle, count held at 4 or 5 per edge timing, done pulsed. Without ABORT_EN, count reaches 10.
